// File: rtl/glyph_row_fetch_pkg.sv
// Shared constants and fetch-state encoding for the character-ROM glyph row path.
package glyph_row_fetch_pkg;

  localparam int CHAR_W = 16;
  localparam int CHAR_H = 16;
  localparam int CODE_W = 7;
  localparam int ROW_W  = 4;
  localparam int ADDR_W = CODE_W + ROW_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/glyph_row_fetch_if.sv
// Character-ROM read bus: strobe and address out to the ROM, row data back.
interface glyph_row_fetch_if;
  import glyph_row_fetch_pkg::*;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [CHAR_W-1:0] rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);

endinterface

// File: rtl/glyph_row_fetch.sv
// Fetches one glyph row per scan line from the character ROM ahead of the glyph
// and holds it steady across the glyph's horizontal span.
module glyph_row_fetch
  import glyph_row_fetch_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int PREFETCH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        h_val,
  input  logic [9:0]        v_val,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic [CODE_W-1:0] char_code,
  glyph_row_fetch_if.master rom,
  output logic [CHAR_W-1:0] row_out,
  output logic              row_valid
);

  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [CHAR_W-1:0] r_row;
  logic              r_valid;
  logic [10:0]       r_x_end;

  logic [10:0]       w_y_end;
  logic              w_in_win;
  logic [ROW_W-1:0]  w_row_idx;
  logic              w_trig_cond;
  logic              w_cnt_zero;
  logic              w_hold_exit;
  logic              w_rom_en;
  logic              w_load;
  logic              w_capture;
  logic              w_clear;

  // Window compare is done in 11 bits so y_pos near the top of the range cannot wrap.
  assign w_y_end     = {1'b0, y_pos} + 11'(CHAR_H);
  assign w_in_win    = ({1'b0, v_val} >= {1'b0, y_pos}) && ({1'b0, v_val} < w_y_end);
  assign w_row_idx   = ROW_W'(v_val - y_pos);
  assign w_trig_cond = w_in_win && (x_pos >= 10'(PREFETCH)) && (h_val == x_pos - 10'(PREFETCH));
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_hold_exit = ({1'b0, h_val} == r_x_end) || (h_val == 10'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_trig_cond) w_state_next = ADDR;
      ADDR: w_state_next = WAIT;
      WAIT: if (w_cnt_zero) w_state_next = HOLD;
      HOLD: if (w_hold_exit) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_rom_en  = (r_state == ADDR);
    w_load    = (r_state == IDLE) && w_trig_cond;
    w_capture = (r_state == WAIT) && w_cnt_zero;
    w_clear   = (r_state == HOLD) && w_hold_exit;
  end

  // The span end is latched at trigger so a moving x_pos cannot cut the current row short.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_x_end    <= '0;
      r_cnt      <= '0;
      r_row      <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_load) begin
        r_rom_addr <= {char_code, w_row_idx};
        r_x_end    <= {1'b0, x_pos} + 11'(CHAR_W);
      end
      if (r_state == ADDR) begin
        r_cnt <= CNT_W'(ROM_LATENCY - 1);
      end else if ((r_state == WAIT) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_row   <= rom.rom_data;
        r_valid <= 1'b1;
      end else if (w_clear) begin
        r_row   <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign rom.rom_en   = w_rom_en;
  assign rom.rom_addr = r_rom_addr;
  assign row_out      = r_row;
  assign row_valid    = r_valid;

endmodule

// File: tb/tb_glyph_row_fetch.sv
// Drives two glyph_row_fetch instances (ROM latency 1 and 2) over full scan lines
// and checks them each cycle against a trigger/window timeline model.
module tb_glyph_row_fetch;
  import glyph_row_fetch_pkg::*;

  localparam int H_TOTAL = 800;
  localparam int PF      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  h_val, v_val, x_pos, y_pos;
  logic [6:0]  char_code;
  logic [15:0] row_out_a, row_out_b;
  logic        row_valid_a, row_valid_b;
  logic        chk_en;
  int          line_tag;

  glyph_row_fetch_if rom_a ();
  glyph_row_fetch_if rom_b ();

  glyph_row_fetch #(.ROM_LATENCY(1), .PREFETCH(PF)) u_dut_a (
    .clk(clk), .reset(reset), .h_val(h_val), .v_val(v_val), .x_pos(x_pos), .y_pos(y_pos),
    .char_code(char_code), .rom(rom_a), .row_out(row_out_a), .row_valid(row_valid_a)
  );

  glyph_row_fetch #(.ROM_LATENCY(2), .PREFETCH(PF)) u_dut_b (
    .clk(clk), .reset(reset), .h_val(h_val), .v_val(v_val), .x_pos(x_pos), .y_pos(y_pos),
    .char_code(char_code), .rom(rom_b), .row_out(row_out_b), .row_valid(row_valid_b)
  );

  function automatic logic [15:0] rom_fn(input logic [10:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'h9E37;
    return t ^ 16'h5A3C;
  endfunction

  // Synchronous ROMs; data not backed by a read strobe is garbage so mistimed captures show.
  logic [15:0] rom_a_q, rom_b_q1, rom_b_q2;
  always @(posedge clk) begin
    rom_a_q  <= rom_a.rom_en ? rom_fn(rom_a.rom_addr) : 16'($urandom);
    rom_b_q1 <= rom_b.rom_en ? rom_fn(rom_b.rom_addr) : 16'($urandom);
    rom_b_q2 <= rom_b_q1;
  end
  assign rom_a.rom_data = rom_a_q;
  assign rom_b.rom_data = rom_b_q2;

  logic        act_en    [2];
  logic [10:0] act_addr  [2];
  logic [15:0] act_row   [2];
  logic        act_valid [2];
  assign act_en[0]    = rom_a.rom_en;
  assign act_en[1]    = rom_b.rom_en;
  assign act_addr[0]  = rom_a.rom_addr;
  assign act_addr[1]  = rom_b.rom_addr;
  assign act_row[0]   = row_out_a;
  assign act_row[1]   = row_out_b;
  assign act_valid[0] = row_valid_a;
  assign act_valid[1] = row_valid_b;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d tag=%0d)",
               name, act, exp, h_val, v_val, line_tag);
    end
  endtask

  // Timeline model: a fetch is a trigger cycle t; rom_en at t+1, row valid from
  // t+2+latency until the cycle the span-end or line-wrap column is seen.
  int          lat     [2] = '{1, 2};
  int          f_t     [2] = '{-1, -1};
  int          f_xend  [2];
  logic [10:0] f_addr  [2];
  logic [10:0] m_addr  [2] = '{11'd0, 11'd0};
  int          en_cnt  [2];
  int          vld_cnt [2];
  int          cyc = 0;

  always @(negedge clk) begin
    int  vi, yi, xi, hi;
    bit  trig, e_en, e_vld;
    vi = int'(v_val); yi = int'(y_pos); xi = int'(x_pos); hi = int'(h_val);
    trig = (vi >= yi) && (vi < yi + CHAR_H) && (xi >= PF) && (hi == xi - PF);
    for (int d = 0; d < 2; d++) begin
      e_en  = (f_t[d] >= 0) && (cyc == f_t[d] + 1);
      e_vld = (f_t[d] >= 0) && (cyc >= f_t[d] + 2 + lat[d]);
      if (chk_en) begin
        chk(d == 0 ? "rom_en_a" : "rom_en_b", 32'(act_en[d]), 32'(e_en));
        chk(d == 0 ? "rom_addr_a" : "rom_addr_b", 32'(act_addr[d]), 32'(m_addr[d]));
        chk(d == 0 ? "row_valid_a" : "row_valid_b", 32'(act_valid[d]), 32'(e_vld));
        chk(d == 0 ? "row_out_a" : "row_out_b", 32'(act_row[d]),
            32'(e_vld ? rom_fn(f_addr[d]) : 16'h0));
      end
      if (reset) begin
        f_t[d] = -1;
        m_addr[d] = 11'd0;
      end else if (f_t[d] >= 0) begin
        if (e_vld && (hi == f_xend[d] || hi == 0)) f_t[d] = -1;
      end else if (trig) begin
        f_t[d]    = cyc;
        f_addr[d] = {char_code, 4'(vi - yi)};
        f_xend[d] = xi + CHAR_W;
        m_addr[d] = f_addr[d];
      end
      if (hi == 0) begin
        en_cnt[d]  = 0;
        vld_cnt[d] = 0;
      end
      en_cnt[d]  += int'(act_en[d]);
      vld_cnt[d] += int'(act_valid[d]);
    end
    cyc++;

    // Hand-computed expectations for the directed lines.
    case (line_tag)
      1: begin
        if (hi == 96)  chk("t1_en_h96", 32'(act_en[0]), 0);
        if (hi == 97)  chk("t1_en_h97", 32'(act_en[0]), 1);
        if (hi == 97)  chk("t1_addr", 32'(act_addr[0]), 32'h413);
        if (hi == 98)  chk("t1_vld_h98", 32'(act_valid[0]), 0);
        if (hi == 99)  chk("t1_vld_h99", 32'(act_valid[0]), 1);
        if (hi == 99)  chk("t1_row_h99", 32'(act_row[0]), 32'(rom_fn(11'h413)));
        if (hi == 116) chk("t1_vld_h116", 32'(act_valid[0]), 1);
        if (hi == 117) chk("t1_vld_h117", 32'(act_valid[0]), 0);
        if (hi == 117) chk("t1_row_h117", 32'(act_row[0]), 0);
        if (hi == 799) chk("t1_en_count", 32'(en_cnt[0]), 1);
      end
      2: if (hi == 799) chk("t2_no_fetch", 32'(en_cnt[0] + en_cnt[1]), 0);
      3: if (hi == 97) chk("t2_top_row", 32'(act_addr[0]), 32'h410);
      4: if (hi == 97) chk("t2_bottom_row", 32'(act_addr[0]), 32'h41F);
      5: if (hi == 799) chk("t3_x3_no_valid", 32'(en_cnt[0] + vld_cnt[0]), 0);
      6: begin
        if (hi == 1) chk("t3_x4_en_h1", 32'(act_en[0]), 1);
        if (hi == 2) chk("t3_x4_vld_h2", 32'(act_valid[0]), 0);
        if (hi == 3) chk("t3_x4_vld_h3", 32'(act_valid[0]), 1);
        if (hi == 3) chk("t3_x4_row_h3", 32'(act_row[0]), 32'(rom_fn(11'h413)));
      end
      7: if (hi == 110) chk("t4_row_kept", 32'(act_row[0]), 32'(rom_fn(11'h413)));
      8: if (hi == 97) chk("t4_next_addr", 32'(act_addr[0]), 32'h424);
      9: begin
        if (hi == 109) chk("t5_rst_vld", 32'(act_valid[0]), 0);
        if (hi == 109) chk("t5_rst_row", 32'(act_row[0]), 0);
        if (hi == 799) chk("t5_one_fetch", 32'(en_cnt[0]), 1);
      end
      10: begin
        if (hi == 197) chk("t6_en_h197", 32'(act_en[1]), 1);
        if (hi == 198) chk("t6_en_h198", 32'(act_en[1]), 0);
        if (hi == 199) chk("t6_vld_h199", 32'(act_valid[1]), 0);
        if (hi == 200) chk("t6_vld_h200", 32'(act_valid[1]), 1);
        if (hi == 200) chk("t6_row_h200", 32'(act_row[1]), 32'(rom_fn(11'h413)));
        if (hi == 799) chk("t6_pulse_count", 32'(en_cnt[1]), 1);
      end
      11: if (hi == 799) chk("wrap_vld_h799", 32'(act_valid[0]), 1);
      12: begin
        if (hi == 0) chk("wrap_vld_h0", 32'(act_valid[0]), 1);
        if (hi == 1) chk("wrap_vld_h1", 32'(act_valid[0]), 0);
      end
      default: ;
    endcase
  end

  task automatic run_line(input int v, input int x, input int y, input int code,
                          input int chg_h, input int chg_code, input int rst_h, input int tag);
    for (int h = 0; h < H_TOTAL; h++) begin
      @(posedge clk);
      #1;
      h_val     = 10'(h);
      v_val     = 10'(v);
      x_pos     = 10'(x);
      y_pos     = 10'(y);
      char_code = 7'((chg_h >= 0 && h >= chg_h) ? chg_code : code);
      reset     = (h == rst_h);
      line_tag  = tag;
    end
  endtask

  initial begin
    reset = 1'b1; chk_en = 1'b0; line_tag = 0;
    h_val = '0; v_val = '0; x_pos = '0; y_pos = '0; char_code = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_line(53, 100, 50, 'h41, -1, 0, -1, 1);
    run_line(49, 100, 50, 'h41, -1, 0, -1, 2);
    run_line(66, 100, 50, 'h41, -1, 0, -1, 2);
    run_line(50, 100, 50, 'h41, -1, 0, -1, 3);
    run_line(65, 100, 50, 'h41, -1, 0, -1, 4);
    run_line(53, 3,   50, 'h41, -1, 0, -1, 5);
    run_line(53, 4,   50, 'h41, -1, 0, -1, 6);
    run_line(53, 100, 50, 'h41, 105, 'h42, -1, 7);
    run_line(54, 100, 50, 'h42, -1, 0, -1, 8);
    run_line(53, 100, 50, 'h41, -1, 0, 108, 9);
    run_line(53, 200, 50, 'h41, -1, 0, -1, 10);
    run_line(53, 790, 50, 'h41, -1, 0, -1, 11);
    run_line(53, 100, 50, 'h41, -1, 0, -1, 12);

    for (int n = 0; n < 24; n++) begin
      int v, x, code, chg_h, chg_code, rst_h;
      v        = int'($urandom_range(45, 70));
      x        = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 799)) : int'($urandom_range(0, 300));
      code     = int'($urandom_range(0, 127));
      chg_h    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 799)) : -1;
      chg_code = int'($urandom_range(0, 127));
      rst_h    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 799)) : -1;
      run_line(v, x, 50, code, chg_h, chg_code, rst_h, 0);
    end

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
